// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// A request is complete in the cycle where dm_ack is high; dm_rdata is valid in that cycle.
interface memory_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: holds the M register, drives the data-memory bus with a
// wait/timeout FSM, extracts big-endian byte loads, and registers the writeback.
module memory_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 x_valid,
    input  logic [31:0]          x_insn,
    input  logic [31:0]          x_alu_out,
    input  logic [31:0]          x_rb,
    input  logic                 x_dmwe,
    input  logic                 x_rwe,
    input  logic                 x_rdst,
    input  logic                 x_rwd,
    input  logic                 x_dm_byte,
    input  logic                 x_ld_unsigned,
    output logic                 stall,
    memory_stage_if.master       dm,
    output logic [31:0]          mx_bypass,
    output logic [4:0]           mx_dest,
    output logic                 mx_rwe,
    output logic [31:0]          w_data,
    output logic [4:0]           w_dest,
    output logic                 w_rwe,
    output logic                 dm_err
);

    localparam int             CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic        m_valid_reg;
    logic [4:0]  m_dest_reg;
    logic [31:0] m_alu_reg;
    logic [31:0] m_rb_reg;
    logic        m_dmwe_reg;
    logic        m_rwe_reg;
    logic        m_rwd_reg;
    logic        m_byte_reg;
    logic        m_uns_reg;

    logic [4:0]  x_dest;
    logic        mem_op;
    logic [7:0]  lane [4];
    logic [7:0]  ld_byte;
    logic [31:0] ld_data;

    // Only the opcode and the two register fields of the instruction matter here.
    logic unused_insn_bits;
    assign unused_insn_bits = ^{x_insn[25:21], x_insn[10:0]};

    always_comb begin
        x_dest = x_rdst ? x_insn[15:11] : x_insn[20:16];
        if (x_insn[31:26] == 6'b000011) begin
            x_dest = 5'd31;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid_reg <= 1'b0;
            m_dest_reg  <= '0;
            m_alu_reg   <= '0;
            m_rb_reg    <= '0;
            m_dmwe_reg  <= 1'b0;
            m_rwe_reg   <= 1'b0;
            m_rwd_reg   <= 1'b0;
            m_byte_reg  <= 1'b0;
            m_uns_reg   <= 1'b0;
        end else if (!stall) begin
            m_valid_reg <= x_valid;
            if (x_valid) begin
                m_dest_reg <= x_dest;
                m_alu_reg  <= x_alu_out;
                m_rb_reg   <= x_rb;
                m_dmwe_reg <= x_dmwe;
                m_rwe_reg  <= x_rwe;
                m_rwd_reg  <= x_rwd;
                m_byte_reg <= x_dm_byte;
                m_uns_reg  <= x_ld_unsigned;
            end
        end
    end

    assign mem_op = m_valid_reg && (m_rwd_reg || m_dmwe_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (mem_op && !dm.dm_ack) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dm.dm_ack) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    if (cnt_reg != TMAX) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                    if (cnt_reg >= TLAST) begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Once in ERR the request is withdrawn and the pipeline stays frozen until reset.
    assign dm.dm_req   = mem_op && (state_reg != ST_ERR);
    assign dm.dm_we    = m_dmwe_reg;
    assign dm.dm_addr  = {m_alu_reg[31:2], 2'b00};
    assign dm.dm_be    = m_byte_reg ? (4'b1000 >> m_alu_reg[1:0]) : 4'b1111;
    assign dm.dm_wdata = m_byte_reg ? {4{m_rb_reg[7:0]}} : m_rb_reg;
    assign stall       = (state_reg == ST_ERR) || (mem_op && !dm.dm_ack);
    assign dm_err      = (state_reg == ST_ERR);

    // Big-endian lanes: offset 0 is the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = dm.dm_rdata[31 - 8*gi -: 8];
        end
    endgenerate

    assign ld_byte = lane[m_alu_reg[1:0]];
    assign ld_data = m_byte_reg ? {{24{ld_byte[7] & ~m_uns_reg}}, ld_byte} : dm.dm_rdata;

    assign mx_bypass = m_alu_reg;
    assign mx_dest   = m_dest_reg;
    assign mx_rwe    = m_valid_reg && m_rwe_reg && !m_rwd_reg && (m_dest_reg != 5'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            w_rwe  <= 1'b0;
            w_dest <= '0;
            w_data <= '0;
        end else if (!stall && m_valid_reg) begin
            w_rwe  <= m_rwe_reg && (m_dest_reg != 5'd0);
            w_dest <= m_dest_reg;
            w_data <= m_rwd_reg ? ld_data : m_alu_reg;
        end else begin
            w_rwe  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table plus hand-written wait,
// timeout and reset sequences; writebacks are checked against a scoreboard queue.
module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        x_valid = 1'b0;
    logic [31:0] x_insn = '0;
    logic [31:0] x_alu_out = '0;
    logic [31:0] x_rb = '0;
    logic        x_dmwe = 1'b0;
    logic        x_rwe = 1'b0;
    logic        x_rdst = 1'b0;
    logic        x_rwd = 1'b0;
    logic        x_dm_byte = 1'b0;
    logic        x_ld_unsigned = 1'b0;
    logic        stall;
    logic [31:0] mx_bypass;
    logic [4:0]  mx_dest;
    logic        mx_rwe;
    logic [31:0] w_data;
    logic [4:0]  w_dest;
    logic        w_rwe;
    logic        dm_err;

    always #5 clock = ~clock;

    memory_stage_if mif ();

    memory_stage #(.TIMEOUT(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .x_valid       (x_valid),
        .x_insn        (x_insn),
        .x_alu_out     (x_alu_out),
        .x_rb          (x_rb),
        .x_dmwe        (x_dmwe),
        .x_rwe         (x_rwe),
        .x_rdst        (x_rdst),
        .x_rwd         (x_rwd),
        .x_dm_byte     (x_dm_byte),
        .x_ld_unsigned (x_ld_unsigned),
        .stall         (stall),
        .dm            (mif),
        .mx_bypass     (mx_bypass),
        .mx_dest       (mx_dest),
        .mx_rwe        (mx_rwe),
        .w_data        (w_data),
        .w_dest        (w_dest),
        .w_rwe         (w_rwe),
        .dm_err        (dm_err)
    );

    int checks = 0;
    int errors = 0;

    // Data-memory model: acks once a request has been pending ack_lat cycles.
    int          ack_lat = 0;
    bit          mem_on = 1'b1;
    bit          force_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          req_cnt = 0;

    always_comb mif.dm_ack = force_ack || (mif.dm_req && mem_on && (req_cnt >= ack_lat));
    always_comb mif.dm_rdata = mem_rdata;

    always @(posedge clock) begin
        if (reset || !mif.dm_req || mif.dm_ack) req_cnt <= 0;
        else req_cnt <= req_cnt + 1;
    end

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_t;
    wb_t sb_q[$];

    typedef struct {
        logic [31:0] insn, alu, rb, rdata;
        logic        dmwe, rwe, rdst, rwd, byt, uns;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mxrwe;
        logic        e_wrwe;
        logic [4:0]  e_dest;
        logic [31:0] e_data;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        return {op, 5'd1, rt, rd, 11'd0};
    endfunction

    // Writeback monitor: every w_rwe pulse must match the oldest expected retirement.
    always @(negedge clock) begin
        if (!reset && w_rwe) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got dest %0d data 0x%h required no writeback", w_dest, w_data);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                chk("wb_dest", 32'(w_dest), 32'(e.dest));
                chk("wb_data", w_data, e.data);
                $display("wb dest=%0d data=0x%h", w_dest, w_data);
            end
        end
    end

    // Presents one instruction, holds it while stall is high, returns stall cycles seen.
    task automatic send(input logic [31:0] insn, input logic [31:0] alu, input logic [31:0] rb,
                        input logic dmwe, input logic rwe, input logic rdst, input logic rwd,
                        input logic byt, input logic uns, output int stalls);
        logic st;
        bit   done;
        x_insn = insn; x_alu_out = alu; x_rb = rb;
        x_dmwe = dmwe; x_rwe = rwe; x_rdst = rdst; x_rwd = rwd;
        x_dm_byte = byt; x_ld_unsigned = uns;
        x_valid = 1'b1;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            st = stall;
            @(posedge clock);
            #1;
            if (!st) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got stall held 50 cycles required capture");
        end
        x_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dm_err"}, 32'(dm_err), 32'd0);
        chk({tag, "_stall"},  32'(stall),  32'd0);
        chk({tag, "_dm_req"}, 32'(mif.dm_req), 32'd0);
        chk({tag, "_w_rwe"},  32'(w_rwe),  32'd0);
        chk({tag, "_w_data"}, w_data,      32'd0);
        chk({tag, "_w_dest"}, 32'(w_dest), 32'd0);
        chk({tag, "_mx_rwe"}, 32'(mx_rwe), 32'd0);
    endtask

    initial begin
        int   st;
        vec_t v;

        //             insn               alu           rb            rdata         dmwe rwe rdst rwd byt uns req be       wdata         mx  wrwe dest   data
        vecs[0]  = '{enc(6'h00, 5'd2, 5'd3),  32'h5,        32'h0,        32'h0,        0, 1, 1, 0, 0, 0, 0, 4'b1111, 32'h0,        1, 1, 5'd3,  32'h5};
        vecs[1]  = '{enc(6'h28, 5'd9, 5'd0),  32'h102,      32'hAB,       32'h0,        1, 0, 0, 0, 1, 0, 1, 4'b0010, 32'hABABABAB, 0, 0, 5'd9,  32'h0};
        vecs[2]  = '{enc(6'h20, 5'd4, 5'd0),  32'h101,      32'h0,        32'h12803456, 0, 1, 0, 1, 1, 0, 1, 4'b0100, 32'h0,        0, 1, 5'd4,  32'hFFFFFF80};
        vecs[3]  = '{enc(6'h24, 5'd4, 5'd0),  32'h101,      32'h0,        32'h12803456, 0, 1, 0, 1, 1, 1, 1, 4'b0100, 32'h0,        0, 1, 5'd4,  32'h00000080};
        vecs[4]  = '{enc(6'h23, 5'd7, 5'd0),  32'h207,      32'h0,        32'hCAFEF00D, 0, 1, 0, 1, 0, 0, 1, 4'b1111, 32'h0,        0, 1, 5'd7,  32'hCAFEF00D};
        vecs[5]  = '{enc(6'h2B, 5'd8, 5'd0),  32'h30,       32'h11223344, 32'h0,        1, 0, 0, 0, 0, 0, 1, 4'b1111, 32'h11223344, 0, 0, 5'd8,  32'h0};
        vecs[6]  = '{32'h0C00_0400,           32'h1004,     32'h0,        32'h0,        0, 1, 0, 0, 0, 0, 0, 4'b1111, 32'h0,        1, 1, 5'd31, 32'h1004};
        vecs[7]  = '{enc(6'h00, 5'd2, 5'd0),  32'h99,       32'h0,        32'h0,        0, 1, 1, 0, 0, 0, 0, 4'b1111, 32'h0,        0, 0, 5'd0,  32'h0};
        vecs[8]  = '{enc(6'h20, 5'd10, 5'd0), 32'h400,      32'h0,        32'h7F000000, 0, 1, 0, 1, 1, 0, 1, 4'b1000, 32'h0,        0, 1, 5'd10, 32'h7F};
        vecs[9]  = '{enc(6'h20, 5'd11, 5'd0), 32'h403,      32'h0,        32'h000000F0, 0, 1, 0, 1, 1, 0, 1, 4'b0001, 32'h0,        0, 1, 5'd11, 32'hFFFFFFF0};
        vecs[10] = '{enc(6'h24, 5'd12, 5'd0), 32'h402,      32'h0,        32'h0000AB00, 0, 1, 0, 1, 1, 1, 1, 4'b0010, 32'h0,        0, 1, 5'd12, 32'hAB};
        vecs[11] = '{enc(6'h28, 5'd9, 5'd0),  32'h500,      32'h123456CD, 32'h0,        1, 0, 0, 0, 1, 0, 1, 4'b1000, 32'hCDCDCDCD, 0, 0, 5'd9,  32'h0};
        vecs[12] = '{enc(6'h28, 5'd9, 5'd0),  32'h503,      32'h7E,       32'h0,        1, 0, 0, 0, 1, 0, 1, 4'b0001, 32'h7E7E7E7E, 0, 0, 5'd9,  32'h0};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state("rst0");

        // Table: zero-wait memory, one instruction at a time.
        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            mem_rdata = v.rdata;
            ack_lat = 0;
            if (v.e_wrwe) sb_q.push_back('{v.e_dest, v.e_data});
            send(v.insn, v.alu, v.rb, v.dmwe, v.rwe, v.rdst, v.rwd, v.byt, v.uns, st);
            chk($sformatf("v%0d_capture_stalls", i), 32'(st), 32'd0);
            @(negedge clock);
            chk($sformatf("v%0d_dm_req", i), 32'(mif.dm_req), 32'(v.e_req));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            if (v.e_req) begin
                chk($sformatf("v%0d_dm_we", i), 32'(mif.dm_we), 32'(v.dmwe));
                chk($sformatf("v%0d_dm_addr", i), mif.dm_addr, v.alu & 32'hFFFF_FFFC);
                chk($sformatf("v%0d_dm_be", i), 32'(mif.dm_be), 32'(v.e_be));
                if (v.dmwe) chk($sformatf("v%0d_dm_wdata", i), mif.dm_wdata, v.e_wdata);
            end
            chk($sformatf("v%0d_mx_bypass", i), mx_bypass, v.alu);
            chk($sformatf("v%0d_mx_rwe", i), 32'(mx_rwe), 32'(v.e_mxrwe));
            chk($sformatf("v%0d_mx_dest", i), 32'(mx_dest), 32'(v.e_dest));
            @(negedge clock);
            chk($sformatf("v%0d_wb_timing", i), 32'(w_rwe), 32'(v.e_wrwe));
        end

        // lw acked after 3 wait cycles; following add is held upstream meanwhile.
        ack_lat = 3;
        mem_rdata = 32'hDEADBEEF;
        sb_q.push_back('{5'd5, 32'hDEADBEEF});
        send(enc(6'h23, 5'd5, 5'd0), 32'h200, 32'h0, 0, 1, 0, 1, 0, 0, st);
        x_insn = enc(6'h00, 5'd2, 5'd6); x_alu_out = 32'h77; x_rb = 32'h0;
        x_dmwe = 0; x_rwe = 1; x_rdst = 1; x_rwd = 0; x_dm_byte = 0; x_ld_unsigned = 0;
        x_valid = 1'b1;
        sb_q.push_back('{5'd6, 32'h77});
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("lw_wait%0d_stall", k), 32'(stall), 32'd1);
            chk($sformatf("lw_wait%0d_no_wb", k), 32'(w_rwe), 32'd0);
            chk($sformatf("lw_wait%0d_mx_held", k), mx_bypass, 32'h200);
        end
        @(negedge clock);
        chk("lw_ack_stall", 32'(stall), 32'd0);
        chk("lw_ack_seen", 32'(mif.dm_ack), 32'd1);
        @(posedge clock);
        #1 x_valid = 1'b0;
        @(negedge clock);
        chk("lw_wb_pulse", 32'(w_rwe), 32'd1);
        chk("held_add_mx_bypass", mx_bypass, 32'h77);
        chk("held_add_mx_rwe", 32'(mx_rwe), 32'd1);
        @(negedge clock);
        chk("held_add_wb", 32'(w_rwe), 32'd1);
        @(negedge clock);
        chk("wb_single_pulse", 32'(w_rwe), 32'd0);

        // Stray acks with no memory op in M are ignored.
        ack_lat = 0;
        force_ack = 1'b1;
        @(negedge clock);
        chk("stray_ack_stall", 32'(stall), 32'd0);
        chk("stray_ack_no_wb", 32'(w_rwe), 32'd0);
        sb_q.push_back('{5'd13, 32'h42});
        send(enc(6'h00, 5'd2, 5'd13), 32'h42, 32'h0, 0, 1, 1, 0, 0, 0, st);
        @(negedge clock);
        chk("stray_ack_alu_req", 32'(mif.dm_req), 32'd0);
        chk("stray_ack_alu_stall", 32'(stall), 32'd0);
        force_ack = 1'b0;
        @(negedge clock);
        chk("stray_ack_alu_wb", 32'(w_rwe), 32'd1);

        // Timeout: no ack ever, TIMEOUT=4.
        mem_on = 1'b0;
        send(enc(6'h23, 5'd15, 5'd0), 32'h600, 32'h0, 0, 1, 0, 1, 0, 0, st);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("to%0d_err_low", k), 32'(dm_err), 32'd0);
            chk($sformatf("to%0d_req", k), 32'(mif.dm_req), 32'd1);
            chk($sformatf("to%0d_stall", k), 32'(stall), 32'd1);
        end
        @(negedge clock);
        chk("to_err_set", 32'(dm_err), 32'd1);
        chk("to_err_req_off", 32'(mif.dm_req), 32'd0);
        chk("to_err_stall", 32'(stall), 32'd1);
        force_ack = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("err_sticky", 32'(dm_err), 32'd1);
            chk("err_stall_stuck", 32'(stall), 32'd1);
            chk("err_no_wb", 32'(w_rwe), 32'd0);
        end
        force_ack = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check_reset_state("rst1");
        mem_on = 1'b1;

        // Recovery after reset.
        sb_q.push_back('{5'd14, 32'h55});
        send(enc(6'h00, 5'd2, 5'd14), 32'h55, 32'h0, 0, 1, 1, 0, 0, 0, st);
        repeat (3) @(negedge clock);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
